// File: rtl/vga_timing_pkg.sv
// Shared timing arithmetic for the gray-scale VGA streaming engine:
// line/frame totals, sync window bounds and counter widths.
package vga_timing_pkg;

    function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
        return act + fp;
    endfunction

    // Last position inside the sync window (inclusive bound avoids overflowing the counter width).
    function automatic int unsigned sync_last(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync);
        return act + fp + sync - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Fetch counter must be able to hold the full active pixel count itself.
    function automatic int unsigned frame_pix_width(input int unsigned h_act, input int unsigned v_act);
        return cnt_width(h_act * v_act + 1);
    endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Small first-word-fall-through prefetch FIFO; a push is accepted while full
// when a pop happens in the same cycle.
module vga_pixel_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_stream_gen.sv
// Gray-scale VGA scanout: programmable timing, pixel-clock prescaler and a
// paced prefetch path from an external streaming pixel source.
module vga_stream_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned GRAY_W     = 4,
    parameter int unsigned DIV_W      = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  pixel_div,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic [GRAY_W-1:0] gray_out,
    output logic              frame_next_pixel_out,
    output logic              frame_reset_out,
    input  logic [GRAY_W-1:0] frame_pixel_in,
    output logic              frame_start_out,
    output logic              underflow_out
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);
    localparam int unsigned FW      = frame_pix_width(H_ACTIVE, V_ACTIVE);
    localparam int unsigned GW      = cnt_width(MIN_GAP + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] HS_LAST    = HW'(sync_last(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] VS_LAST    = VW'(sync_last(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [FW-1:0] FRAME_PIX  = FW'(H_ACTIVE * V_ACTIVE);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP - 1);

    logic [DIV_W-1:0]  presc;
    logic [DIV_W-1:0]  div_q;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [FW-1:0]     fetch_cnt;
    logic [GW-1:0]     gap_cnt;

    logic              tick;
    logic              active;
    logic              h_in_sync;
    logic              v_in_sync;
    logic              start_tick;
    logic              fr_tick;
    logic              pop;
    logic              issue;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [GRAY_W-1:0] fifo_dout;

    always_comb begin
        tick       = (presc == div_q);
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_in_sync  = (h_cnt >= HS_START) && (h_cnt <= HS_LAST);
        v_in_sync  = (v_cnt >= VS_START) && (v_cnt <= VS_LAST);
        start_tick = tick && (h_cnt == '0) && (v_cnt == '0);
        fr_tick    = tick && (h_cnt == '0) && (v_cnt == VS_START);
        pop        = tick && active && !fifo_empty;
        // A slot freed by this cycle's pop may be refilled in the same cycle.
        issue      = rst_n && enable && (!fifo_full || pop) && (gap_cnt == '0)
                     && (fetch_cnt < FRAME_PIX) && !fr_tick;
        fifo_flush = !enable || fr_tick;
    end

    assign frame_next_pixel_out = issue;

    // Tick stage: counters advance and the decoded position is registered onto the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            presc           <= '0;
            div_q           <= pixel_div;
            h_cnt           <= '0;
            v_cnt           <= '0;
            h_sync_out      <= ~SYNC_POL;
            v_sync_out      <= ~SYNC_POL;
            gray_out        <= '0;
            frame_start_out <= 1'b0;
            frame_reset_out <= 1'b0;
            underflow_out   <= 1'b0;
        end else begin
            frame_start_out <= start_tick;
            frame_reset_out <= fr_tick;
            if (tick) begin
                presc <= '0;
                if (start_tick) div_q <= pixel_div;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
                h_sync_out <= h_in_sync ? SYNC_POL : ~SYNC_POL;
                v_sync_out <= v_in_sync ? SYNC_POL : ~SYNC_POL;
                gray_out   <= pop ? fifo_dout : '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (fr_tick) begin
                underflow_out <= 1'b0;
            end else if (tick && active && fifo_empty) begin
                underflow_out <= 1'b1;
            end
        end
    end

    // Fetch pacing: the frame-reset load keeps the source quiet while it rewinds.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            fetch_cnt <= '0;
            gap_cnt   <= '0;
        end else if (fr_tick) begin
            fetch_cnt <= '0;
            gap_cnt   <= GAP_LOAD;
        end else if (issue) begin
            fetch_cnt <= fetch_cnt + 1'b1;
            gap_cnt   <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    vga_pixel_fifo #(
        .WIDTH (GRAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (issue),
        .din   (frame_pixel_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
